mantissa_divider_28: RTL

Iterative, handshaked 28-bit mantissa divider for the posit FMAU datapath; it is the division counterpart to the 28x28 mantissa multiplier. It accepts two normalized unsigned mantissas (hidden bit at bit 27) and produces a left-aligned quotient plus a sticky bit for downstream rounding. Precision is selected per operation with the same 2-bit `op` encoding the multiplier uses. It uses a restoring radix-2 recurrence, optionally radix-4.

---
 rtl/mantissa_div_pkg.sv | 31 +++
 rtl/mantissa_div_step.sv | 23 ++
 rtl/mantissa_divider_28.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/mantissa_div_pkg.sv
// Shared constants, op-mode encoding, iteration counts and FSM state type
// for the iterative mantissa divider.
package mantissa_div_pkg;

  localparam int MANT_W = 28;
  localparam int QUOT_W = MANT_W + 1;

  localparam logic [1:0] OP_P28  = 2'b00;
  localparam logic [1:0] OP_P14  = 2'b01;
  localparam logic [1:0] OP_P7   = 2'b10;
  localparam logic [1:0] OP_P28B = 2'b11;

  localparam logic [4:0] N_P28 = 5'd29;
  localparam logic [4:0] N_P14 = 5'd15;
  localparam logic [4:0] N_P7  = 5'd8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic logic [4:0] iter_count(input logic [1:0] op);
    case (op)
      OP_P14:  return N_P14;
      OP_P7:   return N_P7;
      default: return N_P28;
    endcase
  endfunction

endpackage

// File: rtl/mantissa_div_step.sv
// One restoring radix-2 division step: compare, conditionally subtract,
// then shift the partial remainder left by one.
module mantissa_div_step #(
  parameter int MANT_W = mantissa_div_pkg::MANT_W,
  parameter int QUOT_W = mantissa_div_pkg::QUOT_W
) (
  input  logic [QUOT_W-1:0] r,
  input  logic [MANT_W-1:0] b,
  output logic              q,
  output logic [QUOT_W-1:0] r_next
);

  logic [QUOT_W-1:0] bx;
  logic [QUOT_W-1:0] diff;

  always_comb begin
    bx     = {1'b0, b};
    diff   = r - bx;
    q      = (r >= bx);
    r_next = (q ? diff : r) << 1;
  end

endmodule

// File: rtl/mantissa_divider_28.sv
// Handshaked iterative restoring mantissa divider with left-aligned quotient
// and sticky. Define MANTISSA_DIV_RADIX4_EN to retire two quotient bits per cycle.
module mantissa_divider_28 #(
  parameter int MANT_W = mantissa_div_pkg::MANT_W,
  parameter int QUOT_W = mantissa_div_pkg::QUOT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MANT_W-1:0] A,
  input  logic [MANT_W-1:0] B,
  input  logic [1:0]        op,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [QUOT_W-1:0] quot,
  output logic              sticky,
  output logic              dz
);

  import mantissa_div_pkg::*;

  state_t            state;
  logic [QUOT_W-1:0] r;
  logic [MANT_W-1:0] b_q;
  logic [4:0]        cnt;
  logic [4:0]        off;
  logic [4:0]        idx;
  logic [4:0]        n_sel;
  logic              q0;
  logic [QUOT_W-1:0] r0n;

  mantissa_div_step #(.MANT_W(MANT_W), .QUOT_W(QUOT_W)) u_step0 (
    .r      (r),
    .b      (b_q),
    .q      (q0),
    .r_next (r0n)
  );

`ifdef MANTISSA_DIV_RADIX4_EN
  logic              q1;
  logic [QUOT_W-1:0] r1n;
  logic [4:0]        idx_lo;

  mantissa_div_step #(.MANT_W(MANT_W), .QUOT_W(QUOT_W)) u_step1 (
    .r      (r0n),
    .b      (b_q),
    .q      (q1),
    .r_next (r1n)
  );

  always_comb idx_lo = idx - 5'd1;
`endif

  // cnt counts remaining steps minus one; off left-aligns narrow quotients.
  always_comb begin
    n_sel = iter_count(op);
    idx   = cnt + off;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quot      <= '0;
      sticky    <= 1'b0;
      dz        <= 1'b0;
      r         <= '0;
      b_q       <= '0;
      cnt       <= '0;
      off       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            r        <= {1'b0, A};
            b_q      <= B;
            cnt      <= n_sel - 5'd1;
            off      <= 5'(QUOT_W) - n_sel;
            in_ready <= 1'b0;
            sticky   <= 1'b0;
            if (B[MANT_W-1]) begin
              quot  <= '0;
              dz    <= 1'b0;
              state <= CALC;
            end else begin
              quot  <= '1;
              dz    <= 1'b1;
              state <= DONE;
            end
          end
        end
        CALC: begin
          quot[idx] <= q0;
`ifdef MANTISSA_DIV_RADIX4_EN
          if (cnt == 5'd0) begin
            r         <= r0n;
            sticky    <= (r0n != '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            quot[idx_lo] <= q1;
            r            <= r1n;
            if (cnt == 5'd1) begin
              sticky    <= (r1n != '0);
              out_valid <= 1'b1;
              state     <= DONE;
            end else begin
              cnt <= cnt - 5'd2;
            end
          end
`else
          r <= r0n;
          if (cnt == 5'd0) begin
            sticky    <= (r0n != '0);
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 5'd1;
          end
`endif
        end
        DONE: begin
          // The divide-by-zero path enters DONE directly, so out_valid
          // rises one edge after acceptance there.
          if (!out_valid) begin
            out_valid <= 1'b1;
          end else if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
